// File: rtl/rocc_resp_if.sv
// rocc_resp_if: tag, result, register-file write and RoCC response signals of the writeback stage
interface rocc_resp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int XLEN = 64,
  parameter int REG_ADDR_W = 5
);
  logic tag_push;
  logic [REG_ADDR_W-1:0] tag_rd;
  logic tag_xd;
  logic tag_ready;
  logic in_stb;
  logic [DATA_WIDTH-1:0] in_data;
  logic in_busy;
  logic rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic resp_valid;
  logic resp_ready;
  logic [REG_ADDR_W-1:0] resp_rd;
  logic [XLEN-1:0] resp_data;
  logic busy;
  modport slave (
    input tag_push, tag_rd, tag_xd, in_stb, in_data, resp_ready,
    output tag_ready, in_busy, rf_we, rf_waddr, rf_wdata, resp_valid, resp_rd, resp_data, busy
  );
  modport master (
    output tag_push, tag_rd, tag_xd, in_stb, in_data, resp_ready,
    input tag_ready, in_busy, rf_we, rf_waddr, rf_wdata, resp_valid, resp_rd, resp_data, busy
  );
endinterface

// File: rtl/rocc_resp_unit.sv
// rocc_resp_unit: pairs op-unit results with issue tags, writes the RF and returns RoCC responses (ROCC_RESP_NANBOX_EN: NaN-box resp_data)
module rocc_resp_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int XLEN = 64,
  parameter int DEPTH = 4,
  parameter int REG_ADDR_W = 5
) (
  input logic clk,
  input logic rst,
  rocc_resp_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = REG_ADDR_W + 1 + DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;
  state_t state;
  logic [REG_ADDR_W:0] tag_mem [DEPTH];
  logic [AW-1:0] tag_wp, tag_rp;
  logic [CW-1:0] tag_cnt;
  logic [EW-1:0] res_mem [DEPTH];
  logic [AW-1:0] res_wp, res_rp;
  logic [CW-1:0] res_cnt;
  logic acc_q;
  logic tag_we, accept, res_pop;
  logic [REG_ADDR_W-1:0] head_rd;
  logic head_xd;
  logic [DATA_WIDTH-1:0] head_data;
  logic [XLEN-1:0] head_ext;
  assign bus.tag_ready = tag_cnt != CW'(DEPTH);
  assign bus.in_busy = (tag_cnt == '0) || (res_cnt == CW'(DEPTH)) || acc_q;
  assign tag_we = bus.tag_push && bus.tag_ready;
  assign accept = bus.in_stb && !bus.in_busy;
  assign {head_rd, head_xd, head_data} = res_mem[res_rp];
  assign res_pop = (state == WRITE && !head_xd) || (state == RESP && bus.resp_ready);
  assign bus.busy = (tag_cnt != '0) || (res_cnt != '0) || (state != IDLE);
`ifdef ROCC_RESP_NANBOX_EN
  assign head_ext = {{(XLEN-DATA_WIDTH){1'b1}}, head_data};
`else
  assign head_ext = {{(XLEN-DATA_WIDTH){1'b0}}, head_data};
`endif
  // tag queue: filled at issue, drained one entry per accepted result
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wp <= '0;
      tag_rp <= '0;
      tag_cnt <= '0;
    end else begin
      if (tag_we) tag_mem[tag_wp] <= {bus.tag_rd, bus.tag_xd};
      tag_wp <= tag_we ? tag_wp + AW'(1) : tag_wp;
      tag_rp <= accept ? tag_rp + AW'(1) : tag_rp;
      tag_cnt <= tag_cnt + CW'(tag_we) - CW'(accept);
    end
  end
  // result queue: accepted result joined with its tag, drained by the writeback FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      res_wp <= '0;
      res_rp <= '0;
      res_cnt <= '0;
      acc_q <= 1'b0;
    end else begin
      if (accept) res_mem[res_wp] <= {tag_mem[tag_rp], bus.in_data};
      res_wp <= accept ? res_wp + AW'(1) : res_wp;
      res_rp <= res_pop ? res_rp + AW'(1) : res_rp;
      res_cnt <= res_cnt + CW'(accept) - CW'(res_pop);
      acc_q <= accept;
    end
  end
  // writeback FSM: one RF write per result, then an optional held response
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.rf_we <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rd <= '0;
      bus.resp_data <= '0;
    end else begin
      case (state)
        IDLE: if (res_cnt != '0) begin
          state <= WRITE;
          bus.rf_we <= 1'b1;
          bus.rf_waddr <= head_rd;
          bus.rf_wdata <= head_data;
        end
        WRITE: begin
          bus.rf_we <= 1'b0;
          state <= head_xd ? RESP : IDLE;
          if (head_xd) begin
            bus.resp_valid <= 1'b1;
            bus.resp_rd <= head_rd;
            bus.resp_data <= head_ext;
          end
        end
        RESP: if (bus.resp_ready) begin
          state <= IDLE;
          bus.resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rocc_resp_unit.sv
// tb_rocc_resp_unit: directed scoreboard bench for rocc_resp_unit
module tb_rocc_resp_unit;
  typedef struct packed {logic [4:0] rd; logic [31:0] data;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int wr_seen = 0;
  exp_t exp_wr[$];
  exp_t exp_resp[$];
  exp_t mon_e;
  always #5 clk = ~clk;
  rocc_resp_if #(.DATA_WIDTH(32), .XLEN(64), .REG_ADDR_W(5)) bus ();
  rocc_resp_unit #(.DATA_WIDTH(32), .XLEN(64), .DEPTH(4), .REG_ADDR_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic logic [63:0] ext(input logic [31:0] d);
`ifdef ROCC_RESP_NANBOX_EN
    return {32'hFFFF_FFFF, d};
`else
    return {32'h0, d};
`endif
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_tag(input logic [4:0] rd, input logic xd);
    bus.tag_push = 1'b1;
    bus.tag_rd = rd;
    bus.tag_xd = xd;
    tick();
    bus.tag_push = 1'b0;
  endtask
  task automatic give_result(input logic [4:0] rd, input logic xd, input logic [31:0] d);
    int n;
    bus.in_stb = 1'b1;
    bus.in_data = d;
    exp_wr.push_back({rd, d});
    if (xd) exp_resp.push_back({rd, d});
    n = 0;
    while (bus.in_busy && n < 50) begin
      tick();
      n++;
    end
    chk("accept_timeout", 64'(n < 50), 64'(1));
    tick();
    bus.in_stb = 1'b0;
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
    chk("idle_timeout", bus.busy, 0);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rf_we) begin
        wr_seen++;
        if (exp_wr.size() == 0) chk("wr_unexpected", bus.rf_we, 0);
        else begin
          mon_e = exp_wr.pop_front();
          chk("wr_addr", bus.rf_waddr, mon_e.rd);
          chk("wr_data", bus.rf_wdata, mon_e.data);
        end
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (exp_resp.size() == 0) chk("resp_unexpected", bus.resp_valid, 0);
        else begin
          mon_e = exp_resp.pop_front();
          chk("resp_rd", bus.resp_rd, mon_e.rd);
          chk("resp_data", bus.resp_data, ext(mon_e.data));
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] vals [4];
    int w0;
    vals[0] = 32'h1111_0001;
    vals[1] = 32'h2222_0002;
    vals[2] = 32'h3333_0003;
    vals[3] = 32'h4444_0004;
    bus.tag_push = 1'b0;
    bus.tag_rd = '0;
    bus.tag_xd = 1'b0;
    bus.in_stb = 1'b0;
    bus.in_data = '0;
    bus.resp_ready = 1'b0;
    tick();
    tick();
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tag_ready", bus.tag_ready, 1);
    chk("rst_in_busy", bus.in_busy, 1);
    chk("rst_outs", {bus.rf_waddr, bus.rf_wdata, bus.resp_rd}, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_busy", bus.in_busy, 1);
    push_tag(5'd5, 1'b1);
    chk("t1_in_busy", bus.in_busy, 0);
    bus.in_stb = 1'b1;
    bus.in_data = 32'h3F80_0000;
    exp_wr.push_back({5'd5, 32'h3F80_0000});
    exp_resp.push_back({5'd5, 32'h3F80_0000});
    tick();
    bus.in_stb = 1'b0;
    bus.resp_ready = 1'b1;
    chk("t1_acc_busy", bus.in_busy, 1);
    tick();
    chk("t1_rf_we", bus.rf_we, 1);
    chk("t1_waddr", bus.rf_waddr, 5);
    chk("t1_wdata", bus.rf_wdata, 32'h3F80_0000);
    tick();
    chk("t1_resp_valid", bus.resp_valid, 1);
    chk("t1_rf_we_off", bus.rf_we, 0);
    chk("t1_resp_rd", bus.resp_rd, 5);
    chk("t1_resp_data", bus.resp_data, ext(32'h3F80_0000));
    tick();
    chk("t1_resp_done", bus.resp_valid, 0);
    chk("t1_idle", bus.busy, 0);
    bus.resp_ready = 1'b0;
    push_tag(5'd7, 1'b0);
    bus.in_stb = 1'b1;
    bus.in_data = 32'h4000_0000;
    exp_wr.push_back({5'd7, 32'h4000_0000});
    tick();
    bus.in_stb = 1'b0;
    tick();
    chk("t2_rf_we", bus.rf_we, 1);
    chk("t2_waddr", bus.rf_waddr, 7);
    chk("t2_busy", bus.busy, 1);
    tick();
    chk("t2_rf_we_off", bus.rf_we, 0);
    chk("t2_no_resp", bus.resp_valid, 0);
    chk("t2_idle", bus.busy, 0);
    push_tag(5'd9, 1'b1);
    give_result(5'd9, 1'b1, 32'hC0A0_0000);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", bus.resp_valid, 1);
      chk("bp_rd", bus.resp_rd, 9);
      chk("bp_data", bus.resp_data, ext(32'hC0A0_0000));
      chk("bp_busy", bus.busy, 1);
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("bp_popped", bus.resp_valid, 0);
    chk("bp_idle", bus.busy, 0);
    w0 = wr_seen;
    for (int i = 1; i <= 4; i++) push_tag(5'(i), 1'b1);
    chk("full_tag_ready", bus.tag_ready, 0);
    push_tag(5'd31, 1'b1);
    chk("full_tag_ready2", bus.tag_ready, 0);
    for (int i = 0; i < 4; i++) give_result(5'(i + 1), 1'b1, vals[i]);
    chk("drain_tag_ready", bus.tag_ready, 1);
    push_tag(5'd20, 1'b0);
    bus.in_stb = 1'b1;
    bus.in_data = 32'h0000_0055;
    exp_wr.push_back({5'd20, 32'h0000_0055});
    for (int i = 0; i < 3; i++) begin
      chk("full_in_busy", bus.in_busy, 1);
      tick();
    end
    bus.resp_ready = 1'b1;
    begin
      int n;
      n = 0;
      while (bus.in_busy && n < 50) begin
        tick();
        n++;
      end
      chk("full_accept_timeout", 64'(n < 50), 64'(1));
    end
    tick();
    bus.in_stb = 1'b0;
    wait_idle();
    chk("order_writes", 64'(wr_seen - w0), 64'(5));
    chk("order_wr_left", 64'(exp_wr.size()), 64'(0));
    chk("order_resp_left", 64'(exp_resp.size()), 64'(0));
    bus.in_stb = 1'b1;
    bus.in_data = 32'h0000_0077;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("notag_in_busy", bus.in_busy, 1);
      chk("notag_busy", bus.busy, 0);
    end
    bus.tag_push = 1'b1;
    bus.tag_rd = 5'd11;
    bus.tag_xd = 1'b0;
    chk("notag_push_cycle", bus.in_busy, 1);
    tick();
    bus.tag_push = 1'b0;
    chk("notag_ready", bus.in_busy, 0);
    exp_wr.push_back({5'd11, 32'h0000_0077});
    tick();
    bus.in_stb = 1'b0;
    chk("notag_accepted", bus.in_busy, 1);
    chk("notag_busy_on", bus.busy, 1);
    wait_idle();
    bus.resp_ready = 1'b0;
    for (int i = 12; i <= 14; i++) push_tag(5'(i), 1'b1);
    for (int i = 0; i < 3; i++) give_result(5'(i + 12), 1'b1, vals[i]);
    begin
      int n;
      n = 0;
      while (!bus.resp_valid && n < 50) begin
        tick();
        n++;
      end
      chk("mid_resp_valid", bus.resp_valid, 1);
    end
    chk("mid_busy", bus.busy, 1);
    rst = 1'b1;
    exp_wr.delete();
    exp_resp.delete();
    tick();
    chk("mid_rst_valid", bus.resp_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_tag_ready", bus.tag_ready, 1);
    chk("mid_rst_in_busy", bus.in_busy, 1);
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    w0 = wr_seen;
    repeat (10) tick();
    chk("mid_no_writes", 64'(wr_seen - w0), 64'(0));
    chk("mid_still_idle", bus.busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rocc_resp_unit.md
Name: rocc_resp_unit

Overview:
- Downstream writeback/response stage of the RoCC neurosynapse accelerator.
- Consumes 32-bit results from the operation units over the STB/BUSY handshake and pairs each result, in order, with the destination tag (rd, xd) pushed by the dispatcher at issue.
- For every result, writes the accelerator register file. When xd=1, it also returns a 64-bit RoCC response to the core.

Parameters:
- DATA_WIDTH, 32, result width from the operation unit.
- XLEN, 64, RoCC response data width.
- DEPTH, 4, entries in the tag queue and in the result queue; power of 2, minimum 2.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- tag_push  in  1  dispatcher issues an op; capture tag
- tag_rd  in  REG_ADDR_W  destination register of the issued op
- tag_xd  in  1  issued op expects a core response
- tag_ready  out  1  tag queue not full
- in_stb  in  1  operation unit result strobe
- in_data  in  DATA_WIDTH  operation unit result
- in_busy  out  1  result not accepted this cycle
- rf_we  out  1  register file write enable
- rf_waddr  out  REG_ADDR_W  register file write address
- rf_wdata  out  DATA_WIDTH  register file write data
- resp_valid  out  1  RoCC response valid
- resp_ready  in  1  core accepts response
- resp_rd  out  REG_ADDR_W  response destination register
- resp_data  out  XLEN  response data
- busy  out  1  unit has outstanding work

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock. Reset empties both queues and forces state IDLE.
  - Outputs during and after reset: rf_we=0, resp_valid=0, busy=0, tag_ready=1, in_busy=1 (tag queue empty), rf_waddr/rf_wdata/resp_rd/resp_data=0.
  - Reset asserted mid-operation discards all pending tags, results and any unfinished response. A held resp_valid drops in the cycle after the reset edge.
- Tag queue:
  - Push when tag_push && tag_ready; tag_ready = !full, computed from registered count.
  - A push while full is ignored. There is no same-cycle bypass when full.
- Result acceptance:
  - Accept when in_stb && !in_busy.
  - in_busy = tag queue empty OR result queue full OR accepted_last_cycle.
  - accepted_last_cycle is a register set for exactly one cycle after each accept, mirroring the operation unit's one-cycle busy pulse.
  - On accept: pop the tag head and push {tag_rd, tag_xd, in_data} into the result queue at the same edge.
  - A tag pushed in cycle t can pair with a result no earlier than cycle t+1.
- Ordering: results pair with tags strictly FIFO. Operation units complete in issue order.
- Writeback FSM, states IDLE, WRITE, RESP; all outputs registered:
  - IDLE: result queue non-empty -> WRITE.
  - WRITE: rf_we=1 for exactly one cycle with the head's rd/data. If head xd=1 -> RESP. Otherwise pop head -> IDLE.
  - RESP: resp_valid=1 with resp_rd=head rd and resp_data=extended head data. Hold valid and data stable until resp_ready. On handshake pop head -> IDLE. resp_ready while not in RESP is ignored.
- Latency: accept in cycle t -> rf_we in cycle t+2 -> resp_valid from t+3. Sustained throughput is 1 result per 2 cycles (xd=0) or 3 cycles (xd=1, resp_ready held high).
- Simultaneous events: a result accept and a head pop in the same cycle are both performed; the count is unchanged.
- busy = tag queue non-empty OR result queue non-empty OR state != IDLE.
- Width: resp_data[31:0] = data; the upper bits are set by the optional feature.

Optional Feature:
- Macro: ROCC_RESP_NANBOX_EN.
- Defined: resp_data[XLEN-1:DATA_WIDTH] all ones (RISC-V NaN-boxing of single-precision results).
- Undefined: upper bits zero.
- rf_wdata is unaffected in both cases.

Test Plan:
- Reset check: after reset, outputs take their reset values. Push tag (rd=5, xd=1); in_stb with in_data=0x3F800000 one cycle later; resp_ready=1 -> rf_we in cycle t+2 with waddr=5, wdata=0x3F800000. resp_valid in t+3 with resp_rd=5 and resp_data=0x000000003F800000, or 0xFFFFFFFF3F800000 with ROCC_RESP_NANBOX_EN.
- xd=0: tag (rd=7, xd=0), result 0x40000000 -> a single rf_we pulse with waddr=7; resp_valid never asserts; busy returns to 0 in cycle t+3.
- Backpressure: xd=1 result with resp_ready=0 for 10 cycles -> resp_valid and resp_data stable throughout; the pop occurs only on the handshake cycle.
- Ordering and full: push 4 tags (rd=1..4), stall the FSM via resp_ready=0, then drive 4 results -> tag_ready=0 after the 4th push and in_busy=1 while the result queue is full. Writes and responses come out in rd order 1,2,3,4.
- No tag: in_stb high with the tag queue empty -> in_busy=1; the result is not accepted until a tag is pushed, then it is accepted one cycle later.
- Reset mid-operation: rst asserted while in RESP with 2 queued entries -> resp_valid=0, busy=0, tag_ready=1 next cycle; no further rf_we pulses.
